div_ctrl: RTL

Controller in the EX stage that sequences the 32-bit iterative divider for the pipeline. It accepts one DIV/DIVU request at a time and holds the divider start and operands stable until the divider reports complete. It then writes the quotient and remainder into the architectural HI/LO registers. It also stalls the pipeline, aborts on pipeline flush, and owns the MTHI/MTLO write path.

---
 rtl/div_ctrl_pkg.sv | 30 +++
 rtl/div_ctrl_if.sv | 42 ++++
 rtl/div_ctrl_hilo_regs.sv | 46 ++++
 rtl/div_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and defaults for the EX-stage divider controller and its HI/LO registers.
package div_ctrl_pkg;

  localparam int unsigned DataWDefault  = 32;
  localparam int unsigned MaxCycDefault = 40;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDone  = 2'd2,
    StAbort = 2'd3
  } div_state_e;

  typedef enum logic [1:0] {
    HiloHold = 2'd0,
    HiloCap  = 2'd1,
    HiloExt  = 2'd2
  } hilo_sel_e;

  // MTHI/MTLO comes from a younger instruction, so it beats a coincident divide capture.
  function automatic hilo_sel_e hilo_sel(input logic ext_we, input logic cap_en);
    if (ext_we) begin
      return HiloExt;
    end else if (cap_en) begin
      return HiloCap;
    end
    return HiloHold;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Pipeline and divider signals of the divider controller; slave is the controller side.
interface div_ctrl_if
  import div_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
);
  logic              req_valid;
  logic              req_ready;
  logic              req_signed;
  logic [DATA_W-1:0] req_x;
  logic [DATA_W-1:0] req_y;
  logic              flush;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] hilo_wdata;
  logic              stall;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              dv_start;
  logic              dv_signed;
  logic [DATA_W-1:0] dv_x;
  logic [DATA_W-1:0] dv_y;
  logic              dv_rst;
  logic [DATA_W-1:0] dv_s;
  logic [DATA_W-1:0] dv_r;
  logic              dv_complete;

  modport master (
    output req_valid, req_signed, req_x, req_y, flush, hi_we, lo_we, hilo_wdata,
           dv_s, dv_r, dv_complete,
    input  req_ready, stall, done, err, hi, lo, dv_start, dv_signed, dv_x, dv_y, dv_rst
  );

  modport slave (
    input  req_valid, req_signed, req_x, req_y, flush, hi_we, lo_we, hilo_wdata,
           dv_s, dv_r, dv_complete,
    output req_ready, stall, done, err, hi, lo, dv_start, dv_signed, dv_x, dv_y, dv_rst
  );

endinterface

// File: rtl/div_ctrl_hilo_regs.sv
// Architectural HI/LO registers: divide capture merged with MTHI/MTLO writes.
module div_ctrl_hilo_regs
  import div_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic [DATA_W-1:0] cap_hi,
  input  logic [DATA_W-1:0] cap_lo,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  hilo_sel_e hi_sel, lo_sel;
  logic [DATA_W-1:0] hi_q, lo_q;

  assign hi_sel = hilo_sel(hi_we, cap_en);
  assign lo_sel = hilo_sel(lo_we, cap_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      case (hi_sel)
        HiloExt: hi_q <= wdata;
        HiloCap: hi_q <= cap_hi;
        default: ;
      endcase
      case (lo_sel)
        HiloExt: lo_q <= wdata;
        HiloCap: lo_q <= cap_lo;
        default: ;
      endcase
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/div_ctrl.sv
// EX-stage sequencer for the iterative divider: holds operands, captures HI/LO, stalls, aborts.
// Optional: define DIV_ZERO_FAST_EN to retire zero-divisor requests without starting the divider.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DataWDefault,
  parameter int unsigned MAX_CYC = MaxCycDefault
) (
  input logic       div_clk,
  input logic       rst,
  div_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(MAX_CYC + 1);

  div_state_e        state_q;
  logic [CntW-1:0]   cnt_q, cnt_inc;
  logic [DATA_W-1:0] x_q, y_q;
  logic              signed_q, err_q;
  logic              accept, run_cap, fast_cap, cap_en;
  logic [DATA_W-1:0] cap_hi, cap_lo;

  assign accept  = (state_q == StIdle) && bus.req_valid && !bus.flush;
  assign cnt_inc = cnt_q + CntW'(1);

`ifdef DIV_ZERO_FAST_EN
  assign fast_cap = accept && (bus.req_y == '0);
`else
  assign fast_cap = 1'b0;
`endif

  // Flush discards a result that completes in the same cycle.
  assign run_cap = (state_q == StRun) && bus.dv_complete && !bus.flush;
  assign cap_en  = run_cap || fast_cap;
  assign cap_hi  = fast_cap ? bus.req_x : bus.dv_r;
  assign cap_lo  = fast_cap ? '1 : bus.dv_s;

  always_ff @(posedge div_clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      signed_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            x_q      <= bus.req_x;
            y_q      <= bus.req_y;
            signed_q <= bus.req_signed;
            cnt_q    <= '0;
            state_q  <= fast_cap ? StDone : StRun;
          end
        end
        StRun: begin
          cnt_q <= cnt_inc;
          if (bus.flush) begin
            state_q <= StAbort;
          end else if (bus.dv_complete) begin
            state_q <= StDone;
          end else if (cnt_inc == CntW'(MAX_CYC)) begin
            state_q <= StAbort;
            err_q   <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.stall     = accept || (state_q == StRun);
  assign bus.done      = (state_q == StDone);
  assign bus.err       = err_q;
  assign bus.dv_start  = (state_q == StRun);
  assign bus.dv_rst    = rst || (state_q == StAbort);
  assign bus.dv_x      = x_q;
  assign bus.dv_y      = y_q;
  assign bus.dv_signed = signed_q;

  div_ctrl_hilo_regs #(
    .DATA_W(DATA_W)
  ) u_hilo (
    .clk   (div_clk),
    .rst   (rst),
    .cap_en(cap_en),
    .cap_hi(cap_hi),
    .cap_lo(cap_lo),
    .hi_we (bus.hi_we),
    .lo_we (bus.lo_we),
    .wdata (bus.hilo_wdata),
    .hi    (bus.hi),
    .lo    (bus.lo)
  );

endmodule
